avalon_ram_slave: RTL and testbench
===================================

// Module: avalon_ram_slave
// PURPOSE
// - Avalon-MM slave memory: the responder end of the CPU's master bus (address/read/write/waitrequest/byteenable).
// - Word-organised RAM with a fixed, programmable wait-state count.
// - Side-band preload port lets benches place program words before the CPU leaves reset.
// - Sits between top_level_cpu and the bench; replaces ad-hoc RAM models in CPU tests.
// PARAMETERS
// - DEPTH_LOG2   10            log2 of the number of 32-bit words.
// - BASE_ADDR    32'h00000000  byte address mapped to word 0.
// - WAIT_CYCLES  2             extra WAIT cycles before ACK; 0 is legal.
// PORTS
// - clk           in   1           single clock; all state updates on rising edge.
// - reset         in   1           asynchronous, active-low (0 = in reset).
// - address       in   32          byte address from master.
// - read          in   1           read request.
// - write         in   1           write request.
// - writedata     in   32          write data.
// - byteenable    in   4           lane enables; bit i gates writedata[8i+7:8i].
// - waitrequest   out  1           1 = master must hold the request.
// - readdata      out  32          read data; valid in the cycle waitrequest==0 after a read.
// - load_en       in   1           preload strobe.
// - load_addr     in   DEPTH_LOG2  preload word index.
// - load_data     in   32          preload word.
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, wait counter=0, waitrequest=1, readdata=0.
//   Memory array is NOT cleared by reset.
// - Word index = (address-BASE_ADDR)>>2; address[1:0] ignored.
//   In range iff (address-BASE_ADDR) < 4<<DEPTH_LOG2 (32-bit unsigned compare).
// - FSM: IDLE -> WAIT -> ACK -> IDLE. waitrequest = (state != ACK); registered, so it is 1 whenever idle.
//   - IDLE: read|write sampled high -> WAIT with cnt=WAIT_CYCLES, or straight to ACK if WAIT_CYCLES==0.
//   - WAIT: cnt decrements each cycle; cnt==1 -> ACK.
//   - ACK (exactly 1 cycle, waitrequest=0):
//     - Write: committed at the ACK rising edge, per byteenable lane.
//     - Read: readdata loaded on the WAIT->ACK (or IDLE->ACK) edge, then held until the next read ACK.
//     - Returns to IDLE unconditionally.
// - Latency: request-to-ACK is WAIT_CYCLES+1 cycles (minimum 1).
//   Back-to-back requests are accepted again from IDLE, one cycle after ACK.
// - read & write both high: treated as a write; readdata unchanged.
// - Request dropped during WAIT (protocol violation): return to IDLE next edge; no commit, readdata unchanged.
// - Out-of-range: reads return 32'h0; writes are dropped. Both still complete a normal handshake.
// - byteenable==4'b0000 write: memory unchanged; normal ACK.
// - Preload: load_en==1 writes load_data to mem[load_addr] at the rising edge in any state.
//   If it collides with an ACK write to the same word, the preload wins.
// - Reset asserted mid-transaction: FSM aborts to IDLE; a pending write is not committed.
// CONFIGURATION
// - AVRAM_ACCESS_ERR_EN defined:
//   - Adds output access_err (1 bit, reset 0). Sticky; set in any ACK whose address is out of range or has address[1:0]!=0.
//   - Cleared only by reset.
//   - Misaligned accesses still complete as word accesses.
// - AVRAM_ACCESS_ERR_EN undefined: port and logic absent; behaviour otherwise identical.
// TESTING
// - Reset, no requests: waitrequest==1, readdata==0, state IDLE for 10 cycles.
// - Preload mem[1]=32'h24040020; read 0x04 with WAIT_CYCLES=2: waitrequest high for 3 cycles after request;
//   ACK cycle readdata==32'h24040020.
// - Write 0x08 data 32'hAABBCCDD, byteenable 4'b0101; mem was 0. Then read 0x08 -> 32'h00BB00DD.
// - WAIT_CYCLES=0: read 0x04 then immediate read 0x08 -> each ACK 1 cycle after request; IDLE cycle between ACKs.
// - Read 4<<DEPTH_LOG2 -> readdata==0; access_err==1 if AVRAM_ACCESS_ERR_EN.
//   Write there, then read word 0 -> word 0 unchanged.
// - Write request, reset pulsed low during WAIT -> waitrequest==1 immediately, readdata==0;
//   read back -> old data, write not committed.

Source files
------------

// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave RAM with a fixed wait-state count and a side-band preload port.
// Optional sticky access-error output is enabled by defining AVRAM_ACCESS_ERR_EN.
module avalon_ram_slave #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
`ifdef AVRAM_ACCESS_ERR_EN
    ,
    output logic                  access_err
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_waitrequest;
    logic [31:0]           r_readdata;
    logic [31:0]           r_mem [WORDS];

    logic                  w_req;
    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [31:0]           w_rd_word;
    logic                  w_to_ack;
    logic                  w_commit;

    always_comb begin
        w_req      = read | write;
        w_offset   = address - BASE_ADDR;
        // 33-bit compare so DEPTH_LOG2 up to 30 cannot overflow the limit.
        w_in_range = ({1'b0, w_offset} < (33'd4 << DEPTH_LOG2));
        w_index    = w_offset[DEPTH_LOG2+1:2];
        w_rd_word  = w_in_range ? r_mem[w_index] : 32'h0;
        w_to_ack   = w_req && (((r_state == StIdle) && (WAIT_CYCLES == 0)) ||
                               ((r_state == StWait) && (r_cnt == CNT_W'(1))));
        w_commit   = reset && w_to_ack && write && w_in_range;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_waitrequest <= 1'b1;
            r_readdata    <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state       <= StAck;
                            r_waitrequest <= 1'b0;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                StWait: begin
                    if (!w_req) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state       <= StAck;
                        r_cnt         <= '0;
                        r_waitrequest <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                StAck: begin
                    r_state       <= StIdle;
                    r_waitrequest <= 1'b1;
                end
                default: begin
                    r_state       <= StIdle;
                    r_waitrequest <= 1'b1;
                end
            endcase
            // A simultaneous read+write is a write, so readdata is left alone.
            if (w_to_ack && read && !write) begin
                r_readdata <= w_rd_word;
            end
        end
    end

    // No reset on the array: contents survive reset. Preload is last so it wins.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    r_mem[w_index][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

`ifdef AVRAM_ACCESS_ERR_EN
    logic r_access_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_access_err <= 1'b0;
        end else if (w_to_ack && (!w_in_range || (address[1:0] != 2'b00))) begin
            r_access_err <= 1'b1;
        end
    end

    assign access_err = r_access_err;
`endif

    assign waitrequest = r_waitrequest;
    assign readdata    = r_readdata;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed self-checking bench for avalon_ram_slave: WAIT_CYCLES=2 instance plus a
// zero-wait instance for back-to-back latency.
module tb_avalon_ram_slave;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] address, writedata, readdata, load_data;
    logic        read, write, waitrequest, load_en;
    logic [3:0]  byteenable;
    logic [9:0]  load_addr;
`ifdef AVRAM_ACCESS_ERR_EN
    logic        access_err, access_err_z;
`endif

    logic [31:0] address_z, writedata_z, readdata_z, load_data_z;
    logic        read_z, write_z, waitrequest_z, load_en_z;
    logic [3:0]  byteenable_z;
    logic [9:0]  load_addr_z;

    int n_pass  = 0;
    int n_total = 0;

    int          lat;
    logic [31:0] rdat;

    always #5 clk = ~clk;

    avalon_ram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
`ifdef AVRAM_ACCESS_ERR_EN
        , .access_err(access_err)
`endif
    );

    avalon_ram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(rst_n), .address(address_z), .read(read_z), .write(write_z),
        .writedata(writedata_z), .byteenable(byteenable_z), .waitrequest(waitrequest_z),
        .readdata(readdata_z), .load_en(load_en_z), .load_addr(load_addr_z),
        .load_data(load_data_z)
`ifdef AVRAM_ACCESS_ERR_EN
        , .access_err(access_err_z)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        load_en = 1'b1; load_addr = idx; load_data = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Starts in an idle cycle, holds the request until waitrequest drops (bounded).
    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          output int latency, output logic [31:0] rd_out);
        @(posedge clk); #1;
        read = rd; write = wr; address = addr; writedata = data; byteenable = be;
        latency = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (!waitrequest) begin
                latency = i;
                break;
            end
        end
        rd_out = readdata;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
        load_en = 0; load_addr = '0; load_data = '0;
        address_z = '0; read_z = 0; write_z = 0; writedata_z = '0; byteenable_z = '0;
        load_en_z = 0; load_addr_z = '0; load_data_z = '0;
        repeat (2) @(posedge clk);
        #1 check("rst_wait", {31'b0, waitrequest}, 32'h1);
        check("rst_rdata", readdata, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle_wait", {31'b0, waitrequest}, 32'h1);
            check("idle_rdata", readdata, 32'h0);
        end

        preload(10'd0, 32'hCAFEF00D);
        preload(10'd1, 32'h24040020);
        preload(10'd2, 32'h0);
        preload(10'd3, 32'h11223344);

        bus_op(1, 0, 32'h04, 32'h0, 4'hF, lat, rdat);
        check("rd04_lat", lat, 3);
        check("rd04_data", rdat, 32'h24040020);

        bus_op(0, 1, 32'h08, 32'hAABBCCDD, 4'b0101, lat, rdat);
        check("wr08_lat", lat, 3);
        bus_op(1, 0, 32'h08, 32'h0, 4'hF, lat, rdat);
        check("rd08_lanes", rdat, 32'h00BB00DD);

        bus_op(0, 1, 32'h08, 32'h11111111, 4'b0000, lat, rdat);
        check("wr_be0_lat", lat, 3);
        bus_op(1, 0, 32'h08, 32'h0, 4'hF, lat, rdat);
        check("rd_be0", rdat, 32'h00BB00DD);

`ifdef AVRAM_ACCESS_ERR_EN
        check("err_clean", {31'b0, access_err}, 32'h0);
`endif
        bus_op(1, 0, 32'h1000, 32'h0, 4'hF, lat, rdat);
        check("oor_rd_lat", lat, 3);
        check("oor_rd_data", rdat, 32'h0);
`ifdef AVRAM_ACCESS_ERR_EN
        check("err_oor", {31'b0, access_err}, 32'h1);
`endif
        bus_op(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, lat, rdat);
        check("oor_wr_lat", lat, 3);
        bus_op(1, 0, 32'h0, 32'h0, 4'hF, lat, rdat);
        check("word0_kept", rdat, 32'hCAFEF00D);

        // Misaligned write lands on word 2.
        bus_op(0, 1, 32'h0B, 32'h99887766, 4'b1010, lat, rdat);
        bus_op(1, 0, 32'h08, 32'h0, 4'hF, lat, rdat);
        check("misalign_wr", rdat, 32'h99BB77DD);

        // read+write together is a write; readdata holds the previous read.
        bus_op(1, 1, 32'h0C, 32'h55667788, 4'hF, lat, rdat);
        check("rw_lat", lat, 3);
        check("rw_rdata_held", rdat, 32'h99BB77DD);
        bus_op(1, 0, 32'h0C, 32'h0, 4'hF, lat, rdat);
        check("rw_wrote", rdat, 32'h55667788);

        // Request dropped during WAIT.
        @(posedge clk); #1;
        read = 1'b1; address = 32'h04;
        @(posedge clk); #1;
        check("drop_wait1", {31'b0, waitrequest}, 32'h1);
        read = 1'b0;
        @(posedge clk); #1;
        check("drop_wait2", {31'b0, waitrequest}, 32'h1);
        @(posedge clk); #1;
        check("drop_wait3", {31'b0, waitrequest}, 32'h1);
        check("drop_rdata", readdata, 32'h55667788);
        bus_op(1, 0, 32'h04, 32'h0, 4'hF, lat, rdat);
        check("after_drop_lat", lat, 3);
        check("after_drop_data", rdat, 32'h24040020);

        // Reset pulsed during WAIT of a write.
        @(posedge clk); #1;
        write = 1'b1; address = 32'h08; writedata = 32'h0; byteenable = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_wait", {31'b0, waitrequest}, 32'h1);
        check("midrst_rdata", readdata, 32'h0);
`ifdef AVRAM_ACCESS_ERR_EN
        check("midrst_err", {31'b0, access_err}, 32'h0);
`endif
        write = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        bus_op(1, 0, 32'h08, 32'h0, 4'hF, lat, rdat);
        check("midrst_nocommit", rdat, 32'h99BB77DD);

        // Zero-wait instance: back-to-back reads.
        @(negedge clk);
        load_en_z = 1'b1; load_addr_z = 10'd1; load_data_z = 32'h24040020;
        @(negedge clk);
        load_addr_z = 10'd2; load_data_z = 32'h13579BDF;
        @(negedge clk);
        load_en_z = 1'b0;
        @(posedge clk); #1;
        check("z_idle", {31'b0, waitrequest_z}, 32'h1);
        read_z = 1'b1; address_z = 32'h04;
        @(posedge clk); #1;
        check("z_ack1", {31'b0, waitrequest_z}, 32'h0);
        check("z_data1", readdata_z, 32'h24040020);
        read_z = 1'b0;
        @(posedge clk); #1;
        check("z_gap", {31'b0, waitrequest_z}, 32'h1);
        read_z = 1'b1; address_z = 32'h08;
        @(posedge clk); #1;
        check("z_ack2", {31'b0, waitrequest_z}, 32'h0);
        check("z_data2", readdata_z, 32'h13579BDF);
        read_z = 1'b0;
        @(posedge clk); #1;
        check("z_end", {31'b0, waitrequest_z}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
